// File: rtl/vram_blit_engine_pkg.sv
// Shared types and helpers for the VRAM blit engine.
//   addr_t / word_t : 16-bit VRAM address and data word
//   blit_state_t    : blit engine FSM states
//   blit_step       : wrap-around address increment/decrement
//   blit_transp_mask: per-nibble transparency mask (used when BLIT_TRANSP_EN is defined)
package vram_blit_engine_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } blit_state_t;

  // Addresses wrap modulo 2**16 in both directions.
  function automatic addr_t blit_step(input addr_t a, input logic dec);
    return dec ? (a - 16'd1) : (a + 16'd1);
  endfunction

  // A nibble is written only if enabled in the mask and the source nibble is non-zero.
  function automatic logic [3:0] blit_transp_mask(input word_t w, input logic [3:0] m);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[i] = m[i] & (w[i*4 +: 4] != 4'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/vram_blit_engine_if.sv
// Blit request bus between the blit engine (master) and vram_arb (slave).
//   blit_sel_o     : VRAM request
//   blit_ack_i     : grant ack from arbiter (cycle after grant)
//   blit_wr_o      : request is a write
//   blit_wr_mask_o : nibble write mask
//   blit_addr_o    : request address
//   blit_data_o    : write data
//   vram_data_i    : shared VRAM read data, valid in the ack cycle of a read
interface vram_blit_engine_if;
  import vram_blit_engine_pkg::*;

  logic       blit_sel_o;
  logic       blit_ack_i;
  logic       blit_wr_o;
  logic [3:0] blit_wr_mask_o;
  addr_t      blit_addr_o;
  word_t      blit_data_o;
  word_t      vram_data_i;

  modport master (
    output blit_sel_o, blit_wr_o, blit_wr_mask_o, blit_addr_o, blit_data_o,
    input  blit_ack_i, vram_data_i
  );

  modport slave (
    input  blit_sel_o, blit_wr_o, blit_wr_mask_o, blit_addr_o, blit_data_o,
    output blit_ack_i, vram_data_i
  );

endinterface

// File: rtl/vram_blit_engine.sv
// VRAM blit engine: linear fill (constant word) or copy (read src, write dst) of
// count_i words through the lowest-priority vram_arb blit port.
// Ports:
//   clk, reset_n_i          : clock, async active-low reset
//   start_i / abort_i       : begin op (ignored while busy) / stop at next ack
//   copy_i, dec_i           : mode and address direction, latched at start
//   src_addr_i, dst_addr_i  : start addresses
//   count_i                 : word count (0 -> immediate done)
//   fill_data_i, wr_mask_i  : fill word and nibble write mask
//   busy_o, done_o          : op in progress / 1-cycle end pulse
//   blit                    : request bus (vram_blit_engine_if.master)
// Configuration macro: BLIT_TRANSP_EN enables copy-mode nibble transparency.
module vram_blit_engine
  import vram_blit_engine_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             copy_i,
  input  logic             dec_i,
  input  addr_t            src_addr_i,
  input  addr_t            dst_addr_i,
  input  logic [CNT_W-1:0] count_i,
  input  word_t            fill_data_i,
  input  logic [3:0]       wr_mask_i,
  output logic             busy_o,
  output logic             done_o,
  vram_blit_engine_if.master blit
);

  blit_state_t      state_q, state_d;
  addr_t            src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             copy_q, copy_d, dec_q, dec_d, abort_q, abort_d;
  word_t            fill_q, fill_d, data_q, data_d;
  logic [3:0]       mask_q, mask_d, wmask_q, wmask_d;
  logic             sel_q, sel_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic             abort_pend, skip;
  logic [3:0]       rmask;

  // Request outputs stay put through the ack cycle (arbiter only grants on sel & ~ack);
  // the next request is registered on the ack edge, giving 2 cycles per access.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    copy_d  = copy_q;
    dec_d   = dec_q;
    abort_d = abort_q;
    fill_d  = fill_q;
    data_d  = data_q;
    mask_d  = mask_q;
    wmask_d = wmask_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_pend = abort_q | abort_i;
`ifdef BLIT_TRANSP_EN
    rmask = blit_transp_mask(blit.vram_data_i, mask_q);
    skip  = (rmask == 4'h0);
`else
    rmask = mask_q;
    skip  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        sel_d  = 1'b0;
        wr_d   = 1'b0;
        busy_d = 1'b0;
        if (start_i) begin
          if (count_i != '0) begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            cnt_d   = count_i;
            copy_d  = copy_i;
            dec_d   = dec_i;
            fill_d  = fill_data_i;
            mask_d  = wr_mask_i;
            abort_d = 1'b0;
            busy_d  = 1'b1;
            sel_d   = 1'b1;
            if (copy_i) begin
              state_d = RD;
              addr_d  = src_addr_i;
            end else begin
              state_d = WR;
              wr_d    = 1'b1;
              addr_d  = dst_addr_i;
              data_d  = fill_data_i;
              wmask_d = wr_mask_i;
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RD: begin
        abort_d = abort_pend;
        if (blit.blit_ack_i) begin
          src_d = blit_step(src_q, dec_q);
          if (abort_pend) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = 1'b0;
          end else if (skip) begin
            // Fully transparent word: no write, but destination/count still advance.
            dst_d = blit_step(dst_q, dec_q);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              sel_d   = 1'b0;
            end else begin
              addr_d = src_d;
            end
          end else begin
            state_d = WR;
            wr_d    = 1'b1;
            addr_d  = dst_q;
            data_d  = blit.vram_data_i;
            wmask_d = rmask;
          end
        end
      end

      WR: begin
        abort_d = abort_pend;
        if (blit.blit_ack_i) begin
          dst_d = blit_step(dst_q, dec_q);
          cnt_d = cnt_q - CNT_W'(1);
          if ((cnt_q == CNT_W'(1)) || abort_pend) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = 1'b0;
            wr_d    = 1'b0;
          end else if (copy_q) begin
            state_d = RD;
            wr_d    = 1'b0;
            addr_d  = src_q;
          end else begin
            addr_d  = dst_d;
            data_d  = fill_q;
            wmask_d = mask_q;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      copy_q  <= 1'b0;
      dec_q   <= 1'b0;
      abort_q <= 1'b0;
      fill_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wmask_q <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      copy_q  <= copy_d;
      dec_q   <= dec_d;
      abort_q <= abort_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wmask_q <= wmask_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign blit.blit_sel_o     = sel_q;
  assign blit.blit_wr_o      = wr_q;
  assign blit.blit_wr_mask_o = wmask_q;
  assign blit.blit_addr_o    = addr_q;
  assign blit.blit_data_o    = data_q;

endmodule

// File: tb/tb_vram_blit_engine.sv
module tb_vram_blit_engine;
  import vram_blit_engine_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n_i, start_i, abort_i, copy_i, dec_i;
  addr_t       src_addr_i, dst_addr_i;
  logic [15:0] count_i;
  word_t       fill_data_i;
  logic [3:0]  wr_mask_i;
  logic        busy_o, done_o;

  vram_blit_engine_if bif ();

  vram_blit_engine #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .copy_i     (copy_i),
    .dec_i      (dec_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .count_i    (count_i),
    .fill_data_i(fill_data_i),
    .wr_mask_i  (wr_mask_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .blit       (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    addr_t      a;
    word_t      d;
    logic [3:0] m;
  } wr_t;

  wr_t   exp_q[$];
  word_t mem[0:65535];
  int    ack_dly = 1;
  int    cyc;
  logic  any_sel;

  // Arbiter/VRAM model: grant on sel & ~ack, ack ack_dly cycles after grant,
  // request must be stable from grant through ack.
  initial begin
    logic  pend;
    int    cd;
    addr_t g_addr;
    logic  g_wr;
    word_t g_data;
    wr_t   e;
    pend = 1'b0;
    cd = 0;
    g_addr = '0;
    g_wr = 1'b0;
    g_data = '0;
    bif.blit_ack_i  = 1'b0;
    bif.vram_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n_i) begin
        pend = 1'b0;
        bif.blit_ack_i = 1'b0;
      end else if (pend) begin
        chk("hold_sel", {31'd0, bif.blit_sel_o}, 32'd1);
        chk("hold_addr", {16'd0, bif.blit_addr_o}, {16'd0, g_addr});
        chk("hold_wr", {31'd0, bif.blit_wr_o}, {31'd0, g_wr});
        if (g_wr) chk("hold_data", {16'd0, bif.blit_data_o}, {16'd0, g_data});
        if (cd <= 1) begin
          bif.blit_ack_i = 1'b1;
          pend = 1'b0;
          if (g_wr) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_wr", {16'd0, g_addr}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", {16'd0, g_addr}, {16'd0, e.a});
              chk("wr_data", {16'd0, g_data}, {16'd0, e.d});
              chk("wr_mask", {28'd0, bif.blit_wr_mask_o}, {28'd0, e.m});
            end
            for (int i = 0; i < 4; i++)
              if (bif.blit_wr_mask_o[i]) mem[g_addr][i*4 +: 4] = g_data[i*4 +: 4];
          end else begin
            bif.vram_data_i = mem[g_addr];
          end
        end else begin
          cd--;
        end
      end else begin
        bif.blit_ack_i = 1'b0;
        if (bif.blit_sel_o) begin
          pend   = 1'b1;
          cd     = ack_dly;
          g_addr = bif.blit_addr_o;
          g_wr   = bif.blit_wr_o;
          g_data = bif.blit_data_o;
        end
      end
    end
  end

  task automatic op(input logic cp, input logic dc, input addr_t sa, input addr_t da,
                    input logic [15:0] n, input word_t fd, input logic [3:0] mk,
                    input int n_exp, input int abort_at, input int restart_at,
                    output int done_cyc);
    addr_t sp, dp;
    word_t v;
    sp = sa;
    dp = da;
    for (int i = 0; i < n_exp; i++) begin
      v = cp ? mem[sp] : fd;
      exp_q.push_back('{dp, v, mk});
      sp = dc ? sp - 16'd1 : sp + 16'd1;
      dp = dc ? dp - 16'd1 : dp + 16'd1;
    end
    @(posedge clk);
    #1;
    copy_i = cp; dec_i = dc; src_addr_i = sa; dst_addr_i = da;
    count_i = n; fill_data_i = fd; wr_mask_i = mk;
    start_i = 1'b1;
    abort_i = (abort_at == 0);
    any_sel = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    cyc = 1;
    chk("busy_c1", {31'd0, busy_o}, {31'd0, (n != 16'd0)});
    done_cyc = -1;
    while (cyc <= 400) begin
      any_sel = any_sel | bif.blit_sel_o;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      abort_i = (cyc == abort_at);
      if (cyc == restart_at) begin
        start_i = 1'b1;
        fill_data_i = 16'hDEAD;
        dst_addr_i = 16'h9999;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    else chk("busy_at_done", {31'd0, busy_o}, 32'd0);
    chk("pending_wr", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("done_1cyc", {31'd0, done_o}, 32'd0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {bif.blit_sel_o, bif.blit_wr_o, bif.blit_wr_mask_o, busy_o, done_o,
              bif.blit_addr_o[7:0], bif.blit_data_o[7:0]}, 32'd0);
    chk(tag, {bif.blit_addr_o, bif.blit_data_o}, 32'd0);
  endtask

  initial begin
    int dc;
    word_t sv, ev;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    reset_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; copy_i = 1'b0; dec_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; count_i = '0; fill_data_i = '0; wr_mask_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset_outs");
    reset_n_i = 1'b1;

    // Fill 4 words, ack 1 cycle after sel
    op(1'b0, 1'b0, 16'h0, 16'h1000, 16'd4, 16'hABCD, 4'hF, 4, -1, -1, dc);
    chk("fill_done_cyc", dc, 32'd9);
    for (int i = 0; i < 4; i++) chk("fill_mem", {16'd0, mem[16'h1000 + i]}, 32'h0000ABCD);

    // Copy 3 words increment
    for (int i = 0; i < 3; i++) begin
      mem[16'h2000 + i] = 16'hA5C3 + 16'(i) * 16'h1111;
      mem[16'h3000 + i] = '0;
    end
    op(1'b1, 1'b0, 16'h2000, 16'h3000, 16'd3, 16'h0, 4'hF, 3, -1, -1, dc);
    chk("copy_done_cyc", dc, 32'd13);
    for (int i = 0; i < 3; i++)
      chk("copy_mem", {16'd0, mem[16'h3000 + i]}, {16'd0, 16'hA5C3 + 16'(i) * 16'h1111});

    // Address wrap
    op(1'b0, 1'b0, 16'h0, 16'hFFFE, 16'd4, 16'h1234, 4'hF, 4, -1, -1, dc);
    chk("wrap_done_cyc", dc, 32'd9);
    chk("wrap_mem0", {16'd0, mem[16'hFFFF]}, 32'h1234);
    chk("wrap_mem1", {16'd0, mem[16'h0001]}, 32'h1234);

    // Decrementing copy, partial nibble mask (source nibbles all non-zero)
    for (int i = 0; i < 3; i++) mem[16'h3102 - i] = 16'hFFFF;
    op(1'b1, 1'b1, 16'h2002, 16'h3102, 16'd3, 16'h0, 4'b0110, 3, -1, -1, dc);
    chk("dcopy_done_cyc", dc, 32'd13);
    for (int i = 0; i < 3; i++) begin
      sv = 16'hA5C3 + 16'(2 - i) * 16'h1111;
      ev = {4'hF, sv[11:4], 4'hF};
      chk("dcopy_mem", {16'd0, mem[16'h3102 - i]}, {16'd0, ev});
    end

    // Delayed ack, plus an ignored start while busy
    ack_dly = 5;
    op(1'b0, 1'b0, 16'h0, 16'h0500, 16'd3, 16'h5A5A, 4'hF, 3, -1, 3, dc);
    chk("dly_done_cyc", dc, 32'd19);
    chk("dly_no_restart", {16'd0, mem[16'h9999]}, 32'd0);
    ack_dly = 1;

    // Abort during second write of 8
    op(1'b0, 1'b0, 16'h0, 16'h0800, 16'd8, 16'h7777, 4'hF, 2, 3, -1, dc);
    chk("abort_done_cyc", dc, 32'd5);
    chk("abort_no_3rd", {16'd0, mem[16'h0802]}, 32'd0);

    // Count 0: immediate done, no request
    op(1'b0, 1'b0, 16'h0, 16'h0900, 16'd0, 16'h1111, 4'hF, 0, -1, -1, dc);
    chk("cnt0_done_cyc", dc, 32'd1);
    chk("cnt0_no_sel", {31'd0, any_sel}, 32'd0);

    // Abort in IDLE then start+abort together: start wins, full op runs
    @(posedge clk); #1; abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    op(1'b0, 1'b0, 16'h0, 16'h0A00, 16'd2, 16'h2222, 4'hF, 2, 0, -1, dc);
    chk("startwin_done_cyc", dc, 32'd5);

    // Reset mid-op: everything clears, no done, no write
    @(posedge clk); #1;
    dst_addr_i = 16'h0B00; count_i = 16'd8; fill_data_i = 16'h3333; copy_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("rst_pre_sel", {31'd0, bif.blit_sel_o}, 32'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_outs_zero("rst_mid_outs");
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("rst_hold_outs");
    reset_n_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_done", {31'd0, done_o}, 32'd0);
    end
    chk("rst_no_wr", {16'd0, mem[16'h0B00]}, 32'd0);

    // Recovery after reset
    op(1'b0, 1'b0, 16'h0, 16'h0C00, 16'd1, 16'h4444, 4'hF, 1, -1, -1, dc);
    chk("recover_done_cyc", dc, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
